// File: rtl/fetch_sequencer_pkg.sv
// Shared types and widths for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 18;
    localparam int TOUT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

endpackage

// File: rtl/fetch_timeout.sv
// Fetch wait counter: counts stalled FETCH cycles, flags when the limit is reached.
module fetch_timeout
    import fetch_sequencer_pkg::*;
#(
    parameter logic [TOUT_W-1:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [TOUT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer with fetch timeout fault and retire counter.
//   state    | meaning
//   IDLE     | one cycle after reset release
//   FETCH    | request word at PC, wait for valid or timeout
//   EXEC     | instruction presented to control unit until not stalled
//   HALT     | fetch timed out; frozen until reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter logic [TOUT_W-1:0] TIMEOUT  = 8'd255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [PC_W-1:0]    o_imemAddr,
    output logic               o_imemReq,
    input  logic [INSTR_W-1:0] i_imemData,
    input  logic               i_imemValid,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instrValid,
    input  logic               i_stall,
    input  logic               i_jTaken,
    input  logic [PC_W-1:0]    i_jTarget,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_fault,
    output logic [PC_W-1:0]    o_retired
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fault_q, fault_d;
    logic [PC_W-1:0]    retired_q, retired_d;
    logic               tout_clear, tout_enable, tout_tc;

    fetch_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (tout_clear),
        .enable (tout_enable),
        .tc     (tout_tc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        retired_d   = retired_q;
        tout_clear  = 1'b0;
        tout_enable = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A word arriving on the terminal-count cycle still wins over the fault.
                if (i_imemValid) begin
                    instr_d    = i_imemData;
                    tout_clear = 1'b1;
                    state_d    = ST_EXEC;
                end else if (tout_tc) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    tout_enable = 1'b1;
                end
            end
            ST_EXEC: begin
                if (!i_stall) begin
                    retired_d = retired_q + 1'b1;
                    pc_d      = i_jTaken ? i_jTarget : pc_q + 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign o_imemAddr    = pc_q;
    assign o_pc          = pc_q;
    assign o_imemReq     = (state_q == ST_FETCH);
    assign o_instrValid  = (state_q == ST_EXEC);
    assign o_instruction = instr_q;
    assign o_fault       = fault_q;
    assign o_retired     = retired_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 8'd255: max FETCH-state cycles waiting for i_imemValid before fault.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 o_imemAddr  out  16  program memory address, equals current PC.
REQ-006 o_imemReq  out  1  fetch request, high only in FETCH.
REQ-007 i_imemData  in  18  instruction word from program memory.
REQ-008 i_imemValid  in  1  i_imemData valid this cycle.
REQ-009 o_instruction  out  18  instruction register, feeds control unit.
REQ-010 o_instrValid  out  1  execute strobe, high only in EXEC.
REQ-011 i_stall  in  1  datapath not ready to retire current instruction.
REQ-012 i_jTaken  in  1  jump condition result for current instruction, sampled in EXEC.
REQ-013 i_jTarget  in  16  jump destination, sampled with i_jTaken.
REQ-014 o_pc  out  16  current PC.
REQ-015 o_fault  out  1  sticky fetch-timeout flag.
REQ-016 o_retired  out  16  retired-instruction count.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, HALT; encoding 2 bits.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 FETCH: o_imemReq=1, o_imemAddr=PC; timeout counter increments each cycle i_imemValid=0.
REQ-020 FETCH with i_imemValid=1: o_instruction<=i_imemData, counter<=0, next state EXEC; o_instrValid high the following cycle (1-cycle capture latency).
REQ-021 FETCH with counter==TIMEOUT and i_imemValid=0: o_fault<=1, next state HALT; i_imemValid and timeout in same cycle SHALL favour capture.
REQ-022 i_imemValid outside FETCH SHALL be ignored; o_instruction SHALL not change outside FETCH capture.
REQ-023 EXEC with i_stall=1: remain in EXEC, hold o_instruction, PC, o_instrValid=1, o_retired unchanged.
REQ-024 EXEC with i_stall=0: retire; o_retired<=o_retired+1 (wraps FFFF->0000); next state FETCH.
REQ-025 Retire with i_jTaken=1: PC<=i_jTarget; else PC<=PC+1, wrap 16'hFFFF->16'h0000.
REQ-026 i_jTaken and i_jTarget SHALL be ignored when not retiring (stalled or not EXEC).
REQ-027 HALT: o_imemReq=0, o_instrValid=0, PC and o_retired frozen; exit only via reset.
REQ-028 All outputs SHALL be registered or decoded from state register only; no combinational path from inputs to outputs.

Reset
REQ-029 i_rst_n low SHALL immediately force: state IDLE, PC=RESET_PC, o_instruction=18'h0, o_instrValid=0, o_imemReq=0, o_fault=0, o_retired=0, counter=0.
REQ-030 Reset mid-FETCH or mid-EXEC SHALL abandon the instruction without retiring it; a late i_imemValid after release SHALL be ignored until FETCH.

Structure
REQ-031 Shared package SHALL hold state enum, PC_W=16, INSTR_W=18, TOUT_W=8.
REQ-032 One sub-module fetch_timeout: TOUT_W-bit counter with clear/enable/terminal-count output.

Verification
REQ-033 Reset, memory returns valid on 2nd FETCH cycle with 18'h0ABCD -> o_imemAddr=0000, o_instruction=0ABCD, o_instrValid 1 cycle, o_pc=0001, o_retired=1.
REQ-034 EXEC with i_stall=1 for 3 cycles then 0 -> o_instrValid high 4 cycles, single retire, PC advances once.
REQ-035 Retire with i_jTaken=1, i_jTarget=1234 -> next o_imemAddr=1234; same with i_jTaken=0 at PC=FFFF -> 0000.
REQ-036 TIMEOUT=4, i_imemValid never asserted -> o_fault=1 after counter reaches 4, state HALT, o_imemReq=0 until reset.
REQ-037 i_imemValid coincident with timeout terminal count -> capture, o_fault stays 0.
REQ-038 i_rst_n pulsed low during EXEC with stall -> all outputs to reset values asynchronously, o_retired=0, refetch from RESET_PC.
